// File: rtl/sound_event_player.sv
// sound_event_player
//   Turns raw game event levels into timed tones for the speaker pin.
//   Rising edges are detected on each event channel and held as one-deep
//   pending requests. The lowest pending index wins and is played for
//   DUR_CYCLES clocks, followed by a GAP_CYCLES silent gap. A lower index
//   edge preempts the current tone, and an edge on the playing index
//   restarts it. The square wave comes from a phase accumulator that adds
//   2*freq each clock and wraps at CLK_HZ, toggling tone_o on every wrap.
//
// Ports
//   clk       system clock
//   nRst      asynchronous active-low reset
//   event_i   raw event levels (N_EV), synchronous to clk; index 0 = highest priority
//   mute_i    forces tone_o low without affecting sequencing
//   freq_o    frequency word of the playing tone, 0 when not playing
//   active_o  high while a tone is playing
//   cur_ev_o  index of the playing event, 0 when not playing
//   tone_o    square wave at freq_o
//   done_o    one-cycle pulse when a tone runs its full duration
module sound_event_player #(
  parameter int                 N_EV       = 4,
  parameter int                 FW         = 9,
  parameter logic [N_EV*FW-1:0] FREQ_TABLE = {9'd262, 9'd262, 9'd311, 9'd440},
  parameter int                 CLK_HZ     = 10_000_000,
  parameter int                 DUR_CYCLES = 1_000_000,
  parameter int                 GAP_CYCLES = 50_000,
  localparam int                EW         = (N_EV > 1) ? $clog2(N_EV) : 1
) (
  input  logic            clk,
  input  logic            nRst,
  input  logic [N_EV-1:0] event_i,
  input  logic            mute_i,
  output logic [FW-1:0]   freq_o,
  output logic            active_o,
  output logic [EW-1:0]   cur_ev_o,
  output logic            tone_o,
  output logic            done_o
);

  localparam int             AW       = $clog2(CLK_HZ) + 1;
  localparam int             DW       = (DUR_CYCLES > 1) ? $clog2(DUR_CYCLES) : 1;
  localparam int             GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DW-1:0]  DUR_LOAD = DW'(DUR_CYCLES - 1);
  localparam logic [GW-1:0]  GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [AW-1:0]  CLK_MOD  = AW'(CLK_HZ);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [N_EV-1:0]   s1_q, s2_q, pend_q, pend_d;
  logic [N_EV-1:0]   ev_edge, req;
  logic [EW-1:0]     win, cur_q;
  logic [FW-1:0]     freq_win, freq_q;
  logic [DW-1:0]     dur_cnt_q;
  logic [GW-1:0]     gap_cnt_q;
  logic [AW-1:0]     acc_q, acc_sum;
  logic              tone_q, wrap;
  logic              preempt, hit_cur;
  logic              load, retrig, finish;

  // Request decode: winner, its table entry, and how edges relate to the
  // playing index. No pending bit below cur_q can exist while playing,
  // so the winner on a preempt is always the preempting channel or lower.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    ev_edge  = s1_q & ~s2_q;
    req      = pend_q | ev_edge;
    win      = '0;
    freq_win = '0;
    preempt  = 1'b0;
    hit_cur  = 1'b0;
    for (int i = N_EV - 1; i >= 0; i--) begin
      if (req[i]) win = EW'(i);
    end
    for (int i = 0; i < N_EV; i++) begin
      if (EW'(i) == win)                  freq_win = FREQ_TABLE[i*FW +: FW];
      if (ev_edge[i] && EW'(i) <  cur_q)  preempt  = 1'b1;
      if (ev_edge[i] && EW'(i) == cur_q)  hit_cur  = 1'b1;
    end
  end

  // Phase accumulator step; the sum stays below 2*CLK_HZ so AW bits suffice.
  always_comb begin
    acc_sum = acc_q + AW'({freq_q, 1'b0});
    wrap    = (acc_sum >= CLK_MOD);
  end

  // FSM state register
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state and datapath controls
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    retrig  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          load    = 1'b1;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (preempt) begin
          load = 1'b1;
        end else if (hit_cur) begin
          retrig = 1'b1;
        end else if (dur_cnt_q == '0) begin
          finish = 1'b1;
          if (GAP_CYCLES > 0) state_d = S_GAP;
          else if (|req)      load    = 1'b1;
          else                state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          if (|req) begin
            load    = 1'b1;
            state_d = S_PLAY;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pending update: the loaded channel is consumed; an edge on the playing
  // channel is a retrigger rather than a new request.
  always_comb begin
    pend_d = req;
    for (int i = 0; i < N_EV; i++) begin
      if (load && EW'(i) == win)
        pend_d[i] = 1'b0;
      else if (!load && state_q == S_PLAY && EW'(i) == cur_q)
        pend_d[i] = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge nRst) begin
    // NOTE: every flop is cleared by the async reset, so a reset mid-tone
    // drops the tone and all pending requests at once.
    if (!nRst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      pend_q    <= '0;
      cur_q     <= '0;
      freq_q    <= '0;
      dur_cnt_q <= '0;
      gap_cnt_q <= '0;
      acc_q     <= '0;
      tone_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so s2_q picks up
      // the old s1_q and every flop updates from pre-edge values.
      s1_q   <= event_i;
      s2_q   <= s1_q;
      pend_q <= pend_d;
      if (load) begin
        cur_q     <= win;
        freq_q    <= freq_win;
        dur_cnt_q <= DUR_LOAD;
        acc_q     <= '0;
        tone_q    <= 1'b0;
      end else if (retrig) begin
        dur_cnt_q <= DUR_LOAD;
        acc_q     <= '0;
        tone_q    <= 1'b0;
      end else if (state_q == S_PLAY) begin
        if (dur_cnt_q != '0) dur_cnt_q <= dur_cnt_q - 1'b1;
        acc_q  <= wrap ? (acc_sum - CLK_MOD) : acc_sum;
        tone_q <= tone_q ^ wrap;
      end else begin
        acc_q  <= '0;
        tone_q <= 1'b0;
      end
      if (finish)
        gap_cnt_q <= GAP_LOAD;
      else if (state_q == S_GAP && gap_cnt_q != '0)
        gap_cnt_q <= gap_cnt_q - 1'b1;
    end
  end

  // FSM outputs
  always_comb begin
    active_o = (state_q == S_PLAY);
    freq_o   = active_o ? freq_q : '0;
    cur_ev_o = active_o ? cur_q  : '0;
    tone_o   = active_o & tone_q & ~mute_i;
    done_o   = finish;
  end

endmodule
